// File: rtl/vga_pkg.sv
// Shared VGA timing defaults and pixel types for the display-side raster controller.
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;
  localparam int PIPE_LAT_DEF = 0;

  localparam int H_TOTAL = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  typedef logic [9:0] coord_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

endpackage

// File: rtl/vga_timing_ctrl_if.sv
// Pixel bus between the raster controller, the card renderers and the DAC pins.
interface vga_timing_ctrl_if;
  import vga_pkg::*;

  coord_t     x_cnt;
  coord_t     y_cnt;
  logic       active;
  logic       frame_start;
  logic       line_start;
  logic [7:0] r_data;
  logic [7:0] g_data;
  logic [7:0] b_data;
  logic       vga_hs;
  logic       vga_vs;
  logic       vga_blank_n;
  logic       vga_sync_n;
  logic [7:0] vga_r;
  logic [7:0] vga_g;
  logic [7:0] vga_b;

  modport master (
    output x_cnt, y_cnt, active, frame_start, line_start,
    input  r_data, g_data, b_data,
    output vga_hs, vga_vs, vga_blank_n, vga_sync_n, vga_r, vga_g, vga_b
  );

  modport slave (
    input  x_cnt, y_cnt, active, frame_start, line_start,
    output r_data, g_data, b_data,
    input  vga_hs, vga_vs, vga_blank_n, vga_sync_n, vga_r, vga_g, vga_b
  );

endinterface

// File: rtl/vga_timing_ctrl_sync_delay_line.sv
// Clock-enabled shift register that matches control flags to renderer latency.
module sync_delay_line #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 0,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_wire
      // A zero-latency renderer needs no alignment, so the flags pass straight through.
      logic unused_ok;
      assign unused_ok = ^{clk, rst, ce};
      assign q = d;
    end else begin : g_pipe
      logic [WIDTH-1:0] stage [DEPTH];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
        end else if (ce) begin
          stage[0] <= d;
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign q = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_ctrl.sv
// 640x480@60 raster generator: scan counters to renderers, phase-aligned sync/blank/RGB to the DAC.
module vga_timing_ctrl
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE = H_ACTIVE_DEF,
  parameter int   H_FP     = H_FP_DEF,
  parameter int   H_SYNC   = H_SYNC_DEF,
  parameter int   H_BP     = H_BP_DEF,
  parameter int   V_ACTIVE = V_ACTIVE_DEF,
  parameter int   V_FP     = V_FP_DEF,
  parameter int   V_SYNC   = V_SYNC_DEF,
  parameter int   V_BP     = V_BP_DEF,
  parameter int   PIPE_LAT = PIPE_LAT_DEF,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0
) (
  input logic               clk,
  input logic               rst,
  input logic               pix_ce,
  vga_timing_ctrl_if.master bus
);

  localparam int     H_TOT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int     V_TOT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam coord_t H_LAST   = coord_t'(H_TOT - 1);
  localparam coord_t V_LAST   = coord_t'(V_TOT - 1);
  localparam coord_t H_VIS    = coord_t'(H_ACTIVE);
  localparam coord_t V_VIS    = coord_t'(V_ACTIVE);
  localparam coord_t HS_FIRST = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t HS_LAST  = coord_t'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam coord_t VS_FIRST = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t VS_LAST  = coord_t'(V_ACTIVE + V_FP + V_SYNC - 1);

  coord_t     x_q;
  coord_t     y_q;
  logic       active_c;
  logic       hs_raw;
  logic       vs_raw;
  logic [2:0] flags_d;
  rgb_t       pix_in;
  rgb_t       pix_q;
  logic       hs_q;
  logic       vs_q;
  logic       blank_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
    end else if (pix_ce) begin
      if (x_q == H_LAST) begin
        x_q <= '0;
        y_q <= (y_q == V_LAST) ? '0 : y_q + 10'd1;
      end else begin
        x_q <= x_q + 10'd1;
      end
    end
  end

  assign active_c = (x_q < H_VIS) && (y_q < V_VIS);
  assign hs_raw   = (x_q >= HS_FIRST) && (x_q <= HS_LAST);
  assign vs_raw   = (y_q >= VS_FIRST) && (y_q <= VS_LAST);

  // Flags carry "asserted" sense through the pipe; polarity is applied only at the pins.
  sync_delay_line #(
    .WIDTH  (3),
    .DEPTH  (PIPE_LAT),
    .RST_VAL(3'b000)
  ) u_flag_dly (
    .clk(clk),
    .rst(rst),
    .ce (pix_ce),
    .d  ({hs_raw, vs_raw, active_c}),
    .q  (flags_d)
  );

  assign pix_in = {bus.r_data, bus.g_data, bus.b_data};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_q    <= ~HS_POL;
      vs_q    <= ~VS_POL;
      blank_q <= 1'b0;
      pix_q   <= '0;
    end else if (pix_ce) begin
      hs_q    <= flags_d[2] ? HS_POL : ~HS_POL;
      vs_q    <= flags_d[1] ? VS_POL : ~VS_POL;
      blank_q <= flags_d[0];
      pix_q   <= flags_d[0] ? pix_in : '0;
    end
  end

  assign bus.x_cnt       = x_q;
  assign bus.y_cnt       = y_q;
  assign bus.active      = active_c;
  assign bus.line_start  = pix_ce && (x_q == '0);
  assign bus.frame_start = pix_ce && (x_q == '0) && (y_q == '0);
  assign bus.vga_hs      = hs_q;
  assign bus.vga_vs      = vs_q;
  assign bus.vga_blank_n = blank_q;
  assign bus.vga_sync_n  = 1'b0;
  assign bus.vga_r       = pix_q.r;
  assign bus.vga_g       = pix_q.g;
  assign bus.vga_b       = pix_q.b;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench: full-size zero-latency instance plus a tiny-raster PIPE_LAT=2 instance, both checked every cycle.
module tb_vga_timing_ctrl;
  import vga_pkg::*;

  typedef struct packed {
    int ha, hf, hs, hb, va, vf, vs, vb;
  } tim_t;

  localparam tim_t TA = '{H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF,
                          V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF};
  localparam tim_t TS = '{16, 2, 4, 3, 6, 1, 2, 2};
  localparam int LAT_A = 1;
  localparam int LAT_S = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pix_ce = 1'b0;
  always #10 clk = ~clk;

  vga_timing_ctrl_if bus_a ();
  vga_timing_ctrl_if bus_s ();

  vga_timing_ctrl #(.PIPE_LAT(0)) dut_a (
    .clk(clk), .rst(rst), .pix_ce(pix_ce), .bus(bus_a)
  );

  vga_timing_ctrl #(
    .H_ACTIVE(TS.ha), .H_FP(TS.hf), .H_SYNC(TS.hs), .H_BP(TS.hb),
    .V_ACTIVE(TS.va), .V_FP(TS.vf), .V_SYNC(TS.vs), .V_BP(TS.vb),
    .PIPE_LAT(2)
  ) dut_s (
    .clk(clk), .rst(rst), .pix_ce(pix_ce), .bus(bus_s)
  );

  // Renderers: combinational for dut_a, two pix_ce ticks of latency for dut_s.
  assign bus_a.r_data = bus_a.x_cnt[7:0];
  assign bus_a.g_data = bus_a.y_cnt[7:0];
  assign bus_a.b_data = bus_a.x_cnt[7:0] + bus_a.y_cnt[7:0];

  logic [23:0] rs1 = '0;
  logic [23:0] rs2 = '0;
  always @(posedge clk) begin
    if (pix_ce) begin
      rs1 <= {bus_s.x_cnt[7:0], bus_s.y_cnt[7:0], bus_s.x_cnt[7:0] + bus_s.y_cnt[7:0]};
      rs2 <= rs1;
    end
  end
  assign {bus_s.r_data, bus_s.g_data, bus_s.b_data} = rs2;

  int k;
  int cyc = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) k <= 0;
    else if (pix_ce) k <= k + 1;
  end
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  function automatic void pos(input tim_t t, input int kk, output int x, output int y);
    int ht, idx;
    ht  = t.ha + t.hf + t.hs + t.hb;
    idx = kk % (ht * (t.va + t.vf + t.vs + t.vb));
    x   = idx % ht;
    y   = idx / ht;
  endfunction

  function automatic logic [22:0] exp_cnt(input tim_t t, input int kk, input logic ce);
    int x, y;
    logic act;
    pos(t, kk, x, y);
    act = (x < t.ha) && (y < t.va);
    return {10'(x), 10'(y), act, ce && (x == 0), ce && (x == 0) && (y == 0)};
  endfunction

  function automatic logic [26:0] exp_vga(input tim_t t, input int lat, input int kk);
    int x, y;
    logic act, hs, vs;
    if (kk < lat) return {1'b1, 1'b1, 1'b0, 24'h0};
    pos(t, kk - lat, x, y);
    act = (x < t.ha) && (y < t.va);
    hs  = (x >= t.ha + t.hf) && (x < t.ha + t.hf + t.hs);
    vs  = (y >= t.va + t.vf) && (y < t.va + t.vf + t.vs);
    return {~hs, ~vs, act, act ? {8'(x), 8'(y), 8'(x + y)} : 24'h0};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      if (errors <= 30)
        $display("[TB] FAIL %s at k=%0d cyc=%0d: got %h, expected %h", name, k, cyc, act, expv);
    end
  endtask

  task automatic applyStimulus(input logic rst_v, input logic ce_v);
    @(posedge clk);
    #1;
    rst    = rst_v;
    pix_ce = ce_v;
  endtask

  bit cnt_en = 0;
  bit ls_en = 0;
  int hs_low_a = 0, first_fall_a = -1, fs_a = 0, vs_low_s = 0, fs_s = 0;
  int last_ls = -1, ls_period = -1;

  always @(negedge clk) begin
    checkOutput("cnt_a", {bus_a.x_cnt, bus_a.y_cnt, bus_a.active, bus_a.line_start, bus_a.frame_start},
                exp_cnt(TA, k, pix_ce));
    checkOutput("vga_a", {bus_a.vga_hs, bus_a.vga_vs, bus_a.vga_blank_n, bus_a.vga_r, bus_a.vga_g, bus_a.vga_b},
                exp_vga(TA, LAT_A, k));
    checkOutput("cnt_s", {bus_s.x_cnt, bus_s.y_cnt, bus_s.active, bus_s.line_start, bus_s.frame_start},
                exp_cnt(TS, k, pix_ce));
    checkOutput("vga_s", {bus_s.vga_hs, bus_s.vga_vs, bus_s.vga_blank_n, bus_s.vga_r, bus_s.vga_g, bus_s.vga_b},
                exp_vga(TS, LAT_S, k));
    checkOutput("sync_n", {bus_a.vga_sync_n, bus_s.vga_sync_n}, 64'd0);
    if (cnt_en) begin
      if (!bus_a.vga_hs) begin
        hs_low_a++;
        if (first_fall_a < 0) first_fall_a = k;
      end
      if (bus_a.frame_start) fs_a++;
      if (!bus_s.vga_vs) vs_low_s++;
      if (bus_s.frame_start) fs_s++;
    end
    if (ls_en && bus_a.line_start) begin
      if (last_ls >= 0) ls_period = cyc - last_ls;
      last_ls = cyc;
    end
  end

  initial begin
    repeat (3) applyStimulus(1'b1, 1'b1);

    // Continuous pix_ce from reset release: 1600 ticks sampled.
    applyStimulus(1'b0, 1'b1);
    cnt_en = 1;
    repeat (1599) applyStimulus(1'b0, 1'b1);
    @(negedge clk);
    #1 cnt_en = 0;
    checkOutput("hs_low_ticks_a", 64'(hs_low_a), 64'd192);
    checkOutput("first_hs_fall_a", 64'(first_fall_a), 64'd657);
    checkOutput("frame_starts_a", 64'(fs_a), 64'd1);
    checkOutput("vs_low_ticks_s", 64'(vs_low_s), 64'd297);
    checkOutput("frame_starts_s", 64'(fs_s), 64'd6);

    // pix_ce every other clock: a line must take 1600 clocks.
    ls_en = 1;
    for (int i = 0; i < 3400; i++) applyStimulus(1'b0, (i % 2) == 0);
    @(negedge clk);
    #1 ls_en = 0;
    checkOutput("line_period_a", 64'(ls_period), 64'd1600);

    for (int i = 0; i < 20000; i++) applyStimulus(1'b0, $urandom_range(0, 3) != 0);

    // Mid-frame reset takes effect asynchronously.
    @(posedge clk);
    #1;
    rst    = 1'b1;
    pix_ce = 1'b1;
    #1;
    checkOutput("rst_async_vga_a", {bus_a.vga_hs, bus_a.vga_vs, bus_a.vga_blank_n, bus_a.vga_r, bus_a.vga_g, bus_a.vga_b},
                {37'd0, 3'b110, 24'h0});
    checkOutput("rst_async_cnt_a", {bus_a.x_cnt, bus_a.y_cnt}, 64'd0);
    checkOutput("rst_async_s", {bus_s.x_cnt, bus_s.y_cnt, bus_s.vga_hs, bus_s.vga_vs, bus_s.vga_blank_n, bus_s.vga_r},
                {41'd0, 3'b110, 8'h0});
    repeat (2) applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1);
    @(negedge clk);
    #1;
    checkOutput("post_rst_start_a", {bus_a.x_cnt, bus_a.y_cnt, bus_a.frame_start, bus_a.line_start}, 64'b11);
    checkOutput("post_rst_start_s", {bus_s.x_cnt, bus_s.y_cnt, bus_s.frame_start}, 64'b1);

    for (int i = 0; i < 600; i++) applyStimulus(1'b0, $urandom_range(0, 1) != 0);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_ctrl.md
Name: vga_timing_ctrl

Overview:
Display-side end of the pixel interface used by the card renderers. Generates 640x480@60 VGA raster timing and drives the scan coordinates x_cnt/y_cnt to the renderers. Accepts their combinational or pipelined r/g/b back and outputs sync/blank/RGB to the DE2-115 ADV7123 DAC with all signals phase-aligned. One instance sits at the top level, between the pixel-clock source and all Card instances.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
PIPE_LAT, 0, renderer latency in pix_ce ticks from x_cnt/y_cnt to valid r/g/b (0 = combinational)
HS_POL, 0, hsync active level
VS_POL, 0, vsync active level

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
pix_ce  in  1  pixel clock enable; all state advances only when 1
x_cnt  out  10  current horizontal scan position to renderers
y_cnt  out  10  current vertical scan position to renderers
active  out  1  x_cnt<H_ACTIVE && y_cnt<V_ACTIVE, aligned with x_cnt/y_cnt
frame_start  out  1  high while x_cnt==0 && y_cnt==0 && pix_ce
line_start  out  1  high while x_cnt==0 && pix_ce
r_data  in  8  renderer red
g_data  in  8  renderer green
b_data  in  8  renderer blue
vga_hs  out  1  horizontal sync
vga_vs  out  1  vertical sync
vga_blank_n  out  1  low outside active area
vga_sync_n  out  1  tied 0 (no sync-on-green)
vga_r  out  8  DAC red
vga_g  out  8  DAC green
vga_b  out  8  DAC blue

Behaviour:
- H_TOTAL = sum of H params (800); V_TOTAL = sum of V params (525). Counters 10-bit, unsigned.
- On pix_ce: x increments. At x==H_TOTAL-1, x wraps to 0 and y increments. At y==V_TOTAL-1 together with the x wrap, y wraps to 0. pix_ce=0: all registers hold, including the delay line.
- x_cnt/y_cnt are the counter registers directly. active, frame_start and line_start are combinational from the counters (and pix_ce).
- Raw hs asserted for x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = 656..751. Raw vs asserted for y in 490..491. Raw blank_n = active.
- Raw hs/vs/blank_n pass through a PIPE_LAT-stage delay line clocked on pix_ce. They are then registered once more, together with the incoming r/g/b, in the output register.
- Total latency from a counter value to its vga_* outputs is PIPE_LAT+1 pix_ce ticks.
- vga_r/g/b = delayed blank_n ? r/g/b_data : 0. Renderer output is never passed through during blanking.
- vga_hs = HS_POL when sync asserted, else ~HS_POL. vga_vs follows the same rule with VS_POL.
- Reset values (asynchronous, immediate): x=0, y=0, delay line cleared to inactive, vga_hs=~HS_POL, vga_vs=~VS_POL, vga_blank_n=0, vga_r/g/b=0, vga_sync_n=0.
- Reset mid-frame: outputs go to reset values at once. After release, the first pix_ce tick emits position (0,0) into the pipe, so a frame starts cleanly. No partial-line recovery is performed.
- pix_ce held low continuously: outputs freeze at their last values. No glitches.

Decomposition:
- Package vga_pkg: H_/V_ default timing constants, derived H_TOTAL/V_TOTAL, 10-bit coord_t typedef, rgb_t packed struct {r,g,b} of 8 bits each.
- Sub-module sync_delay_line: parameterized WIDTH/DEPTH shift register with clock enable and asynchronous clear to a parameterized reset value. Depth 0 must elaborate as a wire. Used for {hs,vs,blank_n}.

Test Plan:
- Reset, then pix_ce=1 continuously, PIPE_LAT=0 -> vga_hs low for exactly 96 ticks per 800. First falling edge of vga_hs appears 657 ticks after reset release.
- Full frame run -> vga_vs low for 2 lines = 1600 ticks per 420000-tick frame. frame_start pulses exactly once per 420000 ticks.
- Renderer model returns r_data=x_cnt[7:0] after PIPE_LAT=2 -> at every output tick with vga_blank_n=1, vga_r equals the x it was launched for. vga_r=0 whenever vga_blank_n=0 (e.g. launch x=640 gives vga_r=0).
- pix_ce pulsed 1-in-2 from a 50 MHz clk -> line period is 1600 clk cycles. Outputs remain constant on pix_ce=0 cycles.
- Assert rst at x=300, y=200 for 3 cycles -> outputs return to reset values in the same cycle. The first post-release pix_ce yields x_cnt=0, y_cnt=0 and frame_start=1.
- Counter wrap: observe x 799->0 with y 524->0 -> y_cnt=0, line_start=1, frame_start=1 on the same tick.
